// File: rtl/system_dut_arbiter.sv
// Round-robin burst arbiter: one requester owns the shared valid/ready channel
// for a whole burst (ended by its last beat or the MAX_BEATS cap), then priority rotates.
module system_dut_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [$clog2(NREQ)-1:0] out_src,
    output logic                    busy,
    output logic                    err_ovr
);
    localparam int unsigned SRC_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BEATS - 1);
    localparam logic [SRC_W-1:0] SRC_MAX = SRC_W'(NREQ - 1);

    typedef enum logic [1:0] { IDLE, ARB, BURST } state_t;

    state_t           state_q;
    logic [SRC_W-1:0] ptr_q;
    logic [SRC_W-1:0] gnt_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic             err_ovr_q;

    logic             scan_hit;
    logic [SRC_W-1:0] scan_idx;
    logic [SRC_W-1:0] ptr_d;
    logic             cap_hit;
    logic             beat;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned      cand;
        logic [SRC_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        scan_hit = 1'b0;
        scan_idx = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand     = (32'(ptr_q) + i) % NREQ;
            cand_idx = SRC_W'(cand);
            if (!scan_hit && req_valid[cand_idx]) begin
                scan_hit = 1'b1;
                scan_idx = cand_idx;
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        busy      = 1'b0;
        cap_hit   = (beat_cnt_q == CNT_CAP);
        ptr_d     = (gnt_q == SRC_MAX) ? '0 : gnt_q + 1'b1;
        if (state_q == BURST) begin
            busy             = 1'b1;
            out_valid        = req_valid[gnt_q];
            out_data         = req_data[32'(gnt_q)*DATA_W +: DATA_W];
            out_last         = req_last[gnt_q] | cap_hit;
            req_ready[gnt_q] = out_ready;
        end
        beat = out_valid & out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            err_ovr_q  <= 1'b0;
        end else begin
            err_ovr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) state_q <= ARB;
                end
                ARB: begin
                    if (scan_hit) begin
                        gnt_q   <= scan_idx;
                        state_q <= BURST;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BURST: begin
                    if (beat) begin
                        if (out_last) begin
                            state_q    <= IDLE;
                            beat_cnt_q <= '0;
                            ptr_q      <= ptr_d;
                            // Cap reached without the requester's own last: forced release.
                            err_ovr_q  <= ~req_last[gnt_q];
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_src = gnt_q;
    assign err_ovr = err_ovr_q;

endmodule
